// File: rtl/spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_encoder
// Purpose  : Rate-coding input stage. Streams a 24x24 8-bit image out of pixel
//            BRAM (4 pixels/word, N_WORDS words) once per timestep. Each
//            pixel is compared against a per-lane LFSR random byte, and the
//            resulting 4-bit spike groups go to the presynaptic buffer. The
//            block repeats for i_num_steps timesteps, pacing on i_pre_done.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            i_start           - frame start pulse (accepted in IDLE only)
//            i_num_steps[7:0]  - timesteps per frame, latched at start (0 -> 1)
//            i_pre_done        - buffer finished a timestep
//            addr_p, ce_p      - pixel BRAM read address / chip enable
//            q_p[31:0]         - pixel word, valid one cycle after ce_p
//            o_b_run           - pulse: a timestep's spikes follow
//            o_spike[3:0]      - spike bit per lane, qualified by o_valid
//            o_step[7:0]       - current timestep index
//            o_busy            - high outside IDLE
//            o_frame_done      - pulse after the last timestep completes
//            o_spike_cnt[15:0] - saturating frame spike count
//                                (present only with SPIKE_CNT_EN defined)
// Options  : `define SPIKE_CNT_EN to add the o_spike_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module spike_encoder #(
  parameter int          N_WORDS = 144,
  parameter logic [15:0] SEED0   = 16'hACE1,
  parameter logic [15:0] SEED1   = 16'h1D87,
  parameter logic [15:0] SEED2   = 16'h5A3C,
  parameter logic [15:0] SEED3   = 16'hB00F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [7:0]  i_num_steps,
  input  logic        i_pre_done,
  output logic [7:0]  addr_p,
  output logic        ce_p,
  input  logic [31:0] q_p,
  output logic        o_b_run,
  output logic [3:0]  o_spike,
  output logic        o_valid,
  output logic [7:0]  o_step,
  output logic        o_busy,
  output logic        o_frame_done
`ifdef SPIKE_CNT_EN
  ,
  output logic [15:0] o_spike_cnt
`endif
);

  localparam logic [7:0]       LAST_WORD = 8'(N_WORDS - 1);
  localparam logic [15:0]      TAP_MASK  = 16'hB400;
  localparam logic [3:0][15:0] SEEDS     = {SEED3, SEED2, SEED1, SEED0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       word_q, word_d;
  logic [7:0]       step_q, step_d;
  logic [7:0]       nsteps_q, nsteps_d;
  logic             pend_q, pend_d;
  logic             rd_vld_q, rd_vld_d;
  logic             brun_q, brun_d;
  logic             valid_q, valid_d;
  logic [3:0]       spike_q, spike_d;
  logic [3:0][15:0] lfsr_q, lfsr_d;

  // Galois LFSR, right shift: the bit shifted out conditionally XORs the taps.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? TAP_MASK : 16'h0000);
  endfunction

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    step_d   = step_q;
    nsteps_d = nsteps_q;
    pend_d   = pend_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_FETCH;
          word_d   = 8'd0;
          step_d   = 8'd0;
          nsteps_d = (i_num_steps == 8'd0) ? 8'd1 : i_num_steps;
          pend_d   = 1'b0;
        end
      end
      S_FETCH: begin
        // A done pulse seen while the stream is still in flight is held and
        // only acted on once the pipeline has drained.
        if (i_pre_done) begin
          pend_d = 1'b1;
        end
        if (word_q == LAST_WORD) begin
          state_d = S_WAIT;
        end else begin
          word_d = word_q + 8'd1;
        end
      end
      S_WAIT: begin
        // rd_vld_q high means the last compare is still in the pipe; leaving
        // WAIT only after it clears keeps timesteps from overlapping.
        if ((pend_q || i_pre_done) && !rd_vld_q) begin
          pend_d = 1'b0;
          if (step_q == nsteps_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 8'd1;
            word_d  = 8'd0;
            state_d = S_FETCH;
          end
        end else if (i_pre_done) begin
          pend_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read / compare pipeline
  //   cycle f+k   : ce_p, addr_p = k
  //   cycle f+k+1 : q_p holds word k, compare against LFSRs, LFSRs advance
  //   cycle f+k+2 : registered spike beat k on o_spike / o_valid
  // --------------------------------------------------------------------------
  assign ce_p = (state_q == S_FETCH);

  always_comb begin
    rd_vld_d = ce_p;
    brun_d   = ce_p && (word_q == 8'd0);
    valid_d  = rd_vld_q;
    spike_d  = 4'b0000;
    lfsr_d   = lfsr_q;
    for (int k = 0; k < 4; k++) begin
      if (rd_vld_q) begin
        spike_d[k] = q_p[8*k +: 8] > lfsr_q[k][15:8];
        lfsr_d[k]  = lfsr_next(lfsr_q[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      word_q   <= 8'd0;
      step_q   <= 8'd0;
      nsteps_q <= 8'd1;
      pend_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      brun_q   <= 1'b0;
      valid_q  <= 1'b0;
      spike_q  <= 4'b0000;
      lfsr_q   <= SEEDS;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      step_q   <= step_d;
      nsteps_q <= nsteps_d;
      pend_q   <= pend_d;
      rd_vld_q <= rd_vld_d;
      brun_q   <= brun_d;
      valid_q  <= valid_d;
      spike_q  <= spike_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign addr_p       = word_q;
  assign o_b_run      = brun_q;
  assign o_spike      = spike_q;
  assign o_valid      = valid_q;
  assign o_step       = step_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = (state_q == S_DONE);

`ifdef SPIKE_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating spike counter, accumulated from the registered output beats
  // --------------------------------------------------------------------------
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  pop;
  logic [16:0] cnt_sum;

  always_comb begin
    pop     = {2'b00, spike_q[0]} + {2'b00, spike_q[1]}
            + {2'b00, spike_q[2]} + {2'b00, spike_q[3]};
    cnt_sum = {1'b0, cnt_q} + {14'd0, pop};
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && i_start) begin
      cnt_d = 16'd0;
    end else if (valid_q) begin
      cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_spike_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_encoder
// Purpose  : Self-checking bench for spike_encoder. A scenario table drives
//            whole frames; a reference model (image array + per-lane LFSR
//            random bytes) predicts every spike beat. Hand-written sequences
//            cover reset mid-stream and ignored inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_num_steps = 8'd0;
  logic        i_pre_done = 1'b0;
  logic [7:0]  addr_p;
  logic        ce_p;
  logic [31:0] q_p = 32'd0;
  logic        o_b_run;
  logic [3:0]  o_spike;
  logic        o_valid;
  logic [7:0]  o_step;
  logic        o_busy;
  logic        o_frame_done;
`ifdef SPIKE_CNT_EN
  logic [15:0] o_spike_cnt;
`endif

  always #5 clk = ~clk;

  spike_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_num_steps  (i_num_steps),
    .i_pre_done   (i_pre_done),
    .addr_p       (addr_p),
    .ce_p         (ce_p),
    .q_p          (q_p),
    .o_b_run      (o_b_run),
    .o_spike      (o_spike),
    .o_valid      (o_valid),
    .o_step       (o_step),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
`ifdef SPIKE_CNT_EN
    ,
    .o_spike_cnt  (o_spike_cnt)
`endif
  );

  // Pixel BRAM: one-cycle read latency.
  logic [31:0] mem [144];
  always @(posedge clk) begin
    if (ce_p) q_p <= mem[addr_p];
  end

  // Event monitors (only these processes write these counters).
  int fd_total = 0;
  int brun_total = 0;
  always @(negedge clk) begin
    if (o_frame_done) fd_total++;
    if (o_b_run) brun_total++;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ------------------------------------------------------------------------
  // Reference model: random byte of lane l is the top byte of its LFSR; one
  // LFSR step per emitted beat.
  // ------------------------------------------------------------------------
  int unsigned mlfsr [4];
  int lane0_sp, lane3_sp;
  logic [3:0] first_spike;

  function automatic int unsigned m_next(input int unsigned s);
    return (s >> 1) ^ (((s & 1) != 0) ? 32'hB400 : 32'h0);
  endfunction

  task automatic model_reseed();
    mlfsr[0] = 32'hACE1; mlfsr[1] = 32'h1D87;
    mlfsr[2] = 32'h5A3C; mlfsr[3] = 32'hB00F;
  endtask

  task automatic model_beat(input int k, output logic [3:0] es);
    int unsigned px, rb;
    for (int l = 0; l < 4; l++) begin
      px = (mem[k] >> (8 * l)) & 32'hFF;
      rb = (mlfsr[l] >> 8) & 32'hFF;
      es[l] = (px > rb);
      mlfsr[l] = m_next(mlfsr[l]);
    end
  endtask

  task automatic fill_image(input int pat);
    for (int w = 0; w < 144; w++) begin
      case (pat)
        0:       mem[w] = 32'h0000_0000;
        1:       mem[w] = 32'hFFFF_FFFF;
        2:       mem[w] = {8'd192, 8'd128, 8'd64, 8'd0};
        default: mem[w] = $urandom;
      endcase
    end
  endtask

  typedef struct {
    int pat;            // image pattern
    int nsteps;         // i_num_steps
    int pd_delay;       // cycles from o_b_run to i_pre_done (>=146), or unused
    int pd_beat;        // >=0: pulse i_pre_done during the stream at this beat
    bit start_in_fetch; // pulse an extra i_start mid-stream
    int exp_runs;       // expected o_b_run pulses
    int exp_final_step; // expected o_step after the frame
  } vec_t;

  // ------------------------------------------------------------------------
  // One frame: start, check every timestep's stream, return done, finish.
  // ------------------------------------------------------------------------
  task automatic run_frame(input vec_t v);
    int eff, verr, serr, ferr, fd_base, br_base;
    bit found;
    logic [3:0] es;
    int unsigned exp_cnt;
    eff = (v.nsteps == 0) ? 1 : v.nsteps;
    lane0_sp = 0; lane3_sp = 0; exp_cnt = 0;
    fd_base = fd_total; br_base = brun_total;
    @(negedge clk);
    i_start = 1'b1; i_num_steps = 8'(v.nsteps);
    @(negedge clk);
    i_start = 1'b0; i_num_steps = 8'(v.nsteps + 7);
    check("busy_after_start", o_busy, 1);
    check("first_fetch", {ce_p, addr_p}, {1'b1, 8'd0});
    for (int s = 0; s < eff; s++) begin
      found = 0;
      for (int w = 0; w < 6 && !found; w++) begin
        if (o_b_run) found = 1;
        else @(negedge clk);
      end
      check("b_run_seen", found, 1);
      if (!found) return;
      check("step_index", o_step, s);
      check("fetch_at_run", {ce_p, addr_p}, {1'b1, 8'd1});
      verr = 0; serr = 0; ferr = 0;
      for (int off = 1; off <= 145; off++) begin
        @(negedge clk);
        i_pre_done = 1'b0; i_start = 1'b0;
        if (o_valid !== (off <= 144)) verr++;
        if (o_b_run !== 1'b0) verr++;
        if (off <= 144) begin
          model_beat(off - 1, es);
          if (o_spike !== es) serr++;
          exp_cnt += $countones(es);
          lane0_sp += int'(o_spike[0]);
          lane3_sp += int'(o_spike[3]);
          if (s == 0 && off == 1) first_spike = o_spike;
        end else if (o_spike !== 4'b0000) serr++;
        if (off == 142 && {ce_p, addr_p} !== {1'b1, 8'd143}) ferr++;
        if (off == 143 && ce_p !== 1'b0) ferr++;
        if (v.pd_beat >= 0 && (off == 5 || off == v.pd_beat + 1)) i_pre_done = 1'b1;
        if (v.start_in_fetch && off == 10) begin
          i_start = 1'b1; i_num_steps = 8'd9;
        end
      end
      i_pre_done = 1'b0; i_start = 1'b0;
      check("valid_window", verr, 0);
      check("spike_beats", serr, 0);
      check("fetch_addr", ferr, 0);
      if (v.pd_beat < 0) begin
        repeat (v.pd_delay - 145) @(negedge clk);
        i_pre_done = 1'b1;
        @(negedge clk);
        i_pre_done = 1'b0;
        if (s == eff - 1) check("frame_done_next_cycle", o_frame_done, 1);
        else begin
          @(negedge clk);
          check("b_run_within_2", o_b_run, 1);
        end
      end
    end
    found = 0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clk);
      if (!o_busy) found = 1;
    end
    check("return_idle", found, 1);
    repeat (3) @(negedge clk);
    check("frame_done_count", fd_total - fd_base, 1);
    check("b_run_count", brun_total - br_base, v.exp_runs);
    check("final_step", o_step, v.exp_final_step);
`ifdef SPIKE_CNT_EN
    check("spike_cnt", o_spike_cnt, (exp_cnt > 65535) ? 65535 : exp_cnt);
`endif
  endtask

  vec_t vecs [7];
  vec_t post_reset;

  initial begin
    bit found;
    vecs[0] = '{pat: 2, nsteps: 4, pd_delay: 160, pd_beat: -1, start_in_fetch: 0, exp_runs: 4, exp_final_step: 3};
    vecs[1] = '{pat: 0, nsteps: 1, pd_delay: 150, pd_beat: -1, start_in_fetch: 0, exp_runs: 1, exp_final_step: 0};
    vecs[2] = '{pat: 1, nsteps: 3, pd_delay: 200, pd_beat: -1, start_in_fetch: 0, exp_runs: 3, exp_final_step: 2};
    vecs[3] = '{pat: 3, nsteps: 1, pd_delay: 0,   pd_beat: 100, start_in_fetch: 1, exp_runs: 1, exp_final_step: 0};
    vecs[4] = '{pat: 3, nsteps: 2, pd_delay: 0,   pd_beat: 100, start_in_fetch: 0, exp_runs: 2, exp_final_step: 1};
    vecs[5] = '{pat: 3, nsteps: 0, pd_delay: 170, pd_beat: -1, start_in_fetch: 0, exp_runs: 1, exp_final_step: 0};
    vecs[6] = '{pat: 3, nsteps: 2, pd_delay: int'($urandom_range(146, 260)), pd_beat: -1,
                start_in_fetch: 0, exp_runs: 2, exp_final_step: 1};
    post_reset = '{pat: 2, nsteps: 1, pd_delay: 150, pd_beat: -1, start_in_fetch: 0, exp_runs: 1, exp_final_step: 0};

    model_reseed();
    fill_image(0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {addr_p, ce_p, o_b_run, o_spike, o_valid, o_step, o_busy, o_frame_done}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      fill_image(vecs[i].pat);
      run_frame(vecs[i]);
      if (i == 0) begin
        // Pixels 0/64/128/192 against seed bytes AC/1D/5A/B0.
        check("por_first_beat", first_spike, 4'b1110);
        check("lane0_never_spikes", lane0_sp, 0);
        check("lane3_fraction_ok", (lane3_sp >= 403 && lane3_sp <= 461), 1);
      end
    end

    // i_pre_done in IDLE is ignored.
    @(negedge clk);
    i_pre_done = 1'b1;
    @(negedge clk);
    i_pre_done = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_pre_done_ignored", {o_busy, o_frame_done, o_valid}, 0);

    // Reset at beat 70 of a stream.
    fill_image(3);
    @(negedge clk);
    i_start = 1'b1; i_num_steps = 8'd2;
    @(negedge clk);
    i_start = 1'b0;
    found = 0;
    for (int w = 0; w < 6 && !found; w++) begin
      if (o_b_run) found = 1;
      else @(negedge clk);
    end
    check("reset_test_b_run", found, 1);
    repeat (71) @(negedge clk);
    check("valid_before_reset", o_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("valid_after_reset", o_valid, 0);
    check("outputs_after_reset", {addr_p, ce_p, o_b_run, o_spike, o_valid, o_step, o_busy, o_frame_done}, 0);
    i_start = 1'b1; i_num_steps = 8'd1;
    @(negedge clk);
    check("reset_beats_start", {o_busy, o_valid}, 0);
    i_start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("no_beats_after_reset", {o_busy, o_valid, o_b_run}, 0);
    model_reseed();

    fill_image(post_reset.pat);
    run_frame(post_reset);
    check("reseeded_first_beat", first_spike, 4'b1110);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
- Rate-coding input stage directly upstream of the presynaptic spike buffer.
- Reads a 24x24, 8-bit image from pixel BRAM, four pixels per word, 144 words per frame.
- Each timestep, compares every pixel against a per-lane LFSR random byte and streams 4-bit spike groups with valid to the buffer.
- Repeats for i_num_steps timesteps, pacing on the buffer's done pulse.

Parameters:
- N_WORDS, 144, pixel words per frame (4 pixels each, 576 inputs)
- SEED0, 16'hACE1, lane-0 LFSR seed
- SEED1, 16'h1D87, lane-1 LFSR seed
- SEED2, 16'h5A3C, lane-2 LFSR seed
- SEED3, 16'hB00F, lane-3 LFSR seed

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  frame start pulse
- i_num_steps  in  8  timesteps per frame; sampled at i_start; 0 treated as 1
- i_pre_done  in  1  buffer finished a timestep (one-cycle pulse)
- addr_p  out  8  pixel BRAM address
- ce_p  out  1  pixel BRAM chip enable (read only, no write port)
- q_p  in  32  pixel word; [8k+7:8k] = lane k; valid 1 cycle after ce_p
- o_b_run  out  1  one-cycle pulse to buffer: timestep spikes follow
- o_spike  out  4  spike bit per lane
- o_valid  out  1  o_spike qualifier
- o_step  out  8  current timestep index
- o_busy  out  1  high outside IDLE
- o_frame_done  out  1  one-cycle pulse after last timestep completes

Behaviour:
- Reset: all outputs 0; FSM in IDLE; word counter 0; step counter 0; LFSRs loaded with SEED0..3.
- FSM states: IDLE, FETCH, WAIT, DONE.
- IDLE -> FETCH: on i_start; latch num_steps (0 becomes 1); o_step = 0.
- FETCH: ce_p = 1 and addr_p = k on FETCH cycle k, for k = 0..143. After k = 143, go to WAIT.
- Timing within a timestep, with f = first FETCH cycle:
  - o_b_run high at cycle f+1 only.
  - o_valid high at cycles f+2 .. f+145: exactly 144 consecutive beats.
  - The beat at cycle f+2+k carries word k.
  - The pipeline drains in WAIT.
- Spike rule, per lane k: o_spike[k] = (pixel_k > lfsr_k[15:8]), strict compare.
  - Pixel 0 never spikes.
  - Pixel 255 spikes unless the random byte is 255.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400. Advances once per compare cycle, i.e. once per valid beat; otherwise holds. State persists across timesteps and frames; reloads only on reset.
- o_spike = 0 whenever o_valid = 0.
- WAIT: on i_pre_done:
  - if o_step == num_steps-1, go to DONE;
  - else increment o_step and go to FETCH. The next o_b_run follows within 2 cycles.
- i_pre_done arriving before the last valid beat is registered and acted on after the drain. The next timestep never overlaps the current stream.
- DONE: o_frame_done = 1 for one cycle, then IDLE. o_step holds its final value until the next i_start.
- Ignored events:
  - i_start outside IDLE.
  - i_pre_done in IDLE or FETCH, unless it is registered during drain as above.
- Simultaneous reset with any input: reset wins.
- Reset mid-stream: o_valid drops the next cycle, with no partial beats after.
- Address width: 8 bits. Counter stops at N_WORDS-1 and does not wrap within a timestep.

Optional Feature:
- Macro: SPIKE_CNT_EN.
- Defined:
  - Adds output o_spike_cnt[15:0].
  - Cleared on accepted i_start.
  - Adds popcount(o_spike) on each valid beat.
  - Saturates at 16'hFFFF.
  - Holds after o_frame_done.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- All pixels 8'h00, i_num_steps = 1, i_start -> one o_b_run, 144 valid beats all o_spike = 4'b0000, o_frame_done one cycle after i_pre_done; o_spike_cnt = 0 with SPIKE_CNT_EN.
- All pixels 8'hFF, i_num_steps = 3, i_pre_done returned 200 cycles after each o_b_run -> three o_b_run pulses, each followed next cycle by exactly 144 valid beats; o_step = 0, 1, 2; per-beat spikes match a reference LFSR model (1 only where rand byte != 8'hFF).
- Mixed image, lane k pixels = 64*k -> per-bit match to a reference model over 576 beats (4 steps); lane 0 never spikes; the lane-3 spike fraction is within 192/256 ± 5%.
- i_start during FETCH and i_pre_done during FETCH -> no effect; stream length stays 144; exactly 1 frame done; i_pre_done pulsed at beat 100 is honoured after the drain with no overlap.
- Reset asserted at beat 70 -> o_valid = 0 next cycle; all outputs 0; after release, i_start gives the same first-beat spikes as a power-on run (LFSRs reseeded).
- i_num_steps = 0 -> behaves as 1: single timestep, single o_frame_done.
